// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA accelerator exponentiation blocks.
package rsa_pkg;

    localparam int unsigned MODEXP_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FIND = 3'd1,
        RED  = 3'd2,
        SQR  = 3'd3,
        MUL  = 3'd4,
        DONE = 3'd5
    } modexp_state_t;

endpackage

// File: rtl/mod_mul_serial.sv
// Serial interleaved shift-add modular multiplier: p = (a * b) % m, a < m.
// One b bit per cycle, MSB first; 1 load cycle + WIDTH iteration cycles.
module mod_mul_serial
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = MODEXP_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   acc;

    // One iteration: double with conditional subtract, then conditional add with subtract.
    always_comb begin
        dbl = {p, 1'b0};
        if (dbl >= {1'b0, m_q}) dbl = dbl - {1'b0, m_q};
        acc = dbl;
        if (b_q[WIDTH-1]) acc = dbl + {1'b0, a_q};
        if (acc >= {1'b0, m_q}) acc = acc - {1'b0, m_q};
    end

    // Operand load on start, then WIDTH iterations; done pulses with the final product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            p      <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                m_q    <= m;
                p      <= '0;
                cnt    <= CW'(WIDTH - 1);
                active <= 1'b1;
            end else if (active) begin
                p   <= WIDTH'(acc);
                b_q <= b_q << 1;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lr_binary_modexp.sv
// Left-to-right binary modular exponentiation with a start/busy/done handshake.
module lr_binary_modexp
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = MODEXP_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int unsigned IW = $clog2(WIDTH);

    modexp_state_t    state;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] y_q;
    logic [IW-1:0]    bit_i;
    logic [IW-1:0]    msb_idx;

    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_p;
    logic             mul_done;

    // Priority encoder: index of the most significant set exponent bit.
    always_comb begin
        msb_idx = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            if (exp_q[j]) msb_idx = j[IW-1:0];
        end
    end

    // The multiplier's held product is the running r. The next multiply is
    // launched in the same cycle the previous one reports done, feeding its
    // product straight back, so each multiply costs exactly WIDTH+1 cycles.
    always_comb begin
        mul_start = 1'b0;
        mul_a     = mul_p;
        mul_b     = mul_p;
        case (state)
            FIND: begin
                if (mod_q > WIDTH'(1) && exp_q != '0) begin
                    mul_start = 1'b1;
                    mul_a     = WIDTH'(1);
                    mul_b     = base_q;
                end
            end
            RED, SQR, MUL: begin
                if (mul_done) begin
                    if (state == SQR && exp_q[bit_i]) begin
                        mul_start = 1'b1;
                        mul_b     = y_q;
                    end else if (bit_i != '0) begin
                        mul_start = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rstn  (rstn),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .m     (mod_q),
        .p     (mul_p),
        .done  (mul_done)
    );

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            base_q <= '0;
            exp_q  <= '0;
            mod_q  <= '0;
            y_q    <= '0;
            bit_i  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        mod_q  <= modulus;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= FIND;
                    end
                end
                FIND: begin
                    bit_i <= msb_idx;
                    if (mod_q == '0) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (mod_q == WIDTH'(1)) begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (exp_q == '0) begin
                        result <= WIDTH'(1);
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= RED;
                    end
                end
                RED, SQR, MUL: begin
                    if (mul_done) begin
                        if (state == RED) y_q <= mul_p;
                        if (state == SQR && exp_q[bit_i]) begin
                            state <= MUL;
                        end else if (bit_i == '0) begin
                            result <= mul_p;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            bit_i <= bit_i - 1'b1;
                            state <= SQR;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lr_binary_modexp.sv
// Self-checking bench for lr_binary_modexp: directed table, handshake corners, random regression.
module tb_lr_binary_modexp;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] base;
    logic [31:0] exp;
    logic [31:0] modulus;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    lr_binary_modexp #(.WIDTH(32)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .base    (base),
        .exp     (exp),
        .modulus (modulus),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] m;
        logic [31:0] res;
        logic        er;
        int          lat;
    } vec_t;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endfunction

    // Reference: right-to-left square-and-multiply with 64-bit arithmetic.
    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        longint unsigned r, x, mm;
        if (m == 0) return 32'd0;
        mm = longint'(m);
        r  = 64'd1 % mm;
        x  = longint'(b) % mm;
        for (int k = 0; k < 32; k++) begin
            if (e[k]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] e, input logic [31:0] m);
        int l;
        if (m <= 1 || e == 0) return 2;
        l = 0;
        for (int k = 0; k < 32; k++) if (e[k]) l = k + 1;
        return 2 + 33 * (l + $countones(e) - 1);
    endfunction

    // Accept one operation, scramble inputs after acceptance, wait for done.
    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                          output logic [31:0] res, output logic er, output int lat, output logic tmo);
        @(negedge clk);
        base = b; exp = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = $urandom; exp = $urandom; modulus = $urandom;
        lat = 0; tmo = 1'b1; res = '0; er = 1'b0;
        for (int n = 1; n < 5000; n++) begin
            if (done) begin
                lat = n; res = result; er = err; tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t        vecs[8];
    logic [31:0] r_res;
    logic        r_er;
    int          r_lat;
    logic        r_tmo;
    int          done_seen;
    int          n;

    initial begin
        vecs[0] = '{32'd4,   32'd13,         32'd497,        32'd445, 1'b0, 200};
        vecs[1] = '{32'd100, 32'd3,          32'd7,          32'd1,   1'b0, 101};
        vecs[2] = '{32'd9,   32'd0,          32'd13,         32'd1,   1'b0, 2};
        vecs[3] = '{32'd7,   32'd3,          32'd0,          32'd0,   1'b1, 2};
        vecs[4] = '{32'd5,   32'd9,          32'd1,          32'd0,   1'b0, 2};
        vecs[5] = '{32'd1,   32'hFFFF_FFFF,  32'hFFFF_FFFB,  32'd1,   1'b0, 2081};
        vecs[6] = '{32'd0,   32'd5,          32'd11,         32'd0,   1'b0, 134};
        vecs[7] = '{32'd3,   32'd1,          32'd5,          32'd3,   1'b0, 35};

        rstn = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_err",    {31'd0, err},  32'd0);
        chk("reset_result", result,        32'd0);
        rstn = 1'b1;

        // Directed table
        for (int t = 0; t < 8; t++) begin
            run_op(vecs[t].b, vecs[t].e, vecs[t].m, r_res, r_er, r_lat, r_tmo);
            chk($sformatf("tbl%0d_timeout", t), {31'd0, r_tmo}, 32'd0);
            chk($sformatf("tbl%0d_result",  t), r_res, vecs[t].res);
            chk($sformatf("tbl%0d_err",     t), {31'd0, r_er}, {31'd0, vecs[t].er});
            chk($sformatf("tbl%0d_latency", t), r_lat, vecs[t].lat);
            @(negedge clk);
            chk($sformatf("tbl%0d_busy_after", t), {31'd0, busy}, 32'd0);
            chk($sformatf("tbl%0d_done_pulse", t), {31'd0, done}, 32'd0);
        end

        // Start while busy is ignored
        @(negedge clk);
        base = 32'd4; exp = 32'd13; modulus = 32'd497; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        base = 32'd6; exp = 32'd2; modulus = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 11; r_tmo = 1'b1;
        while (n < 5000) begin
            if (done) begin r_tmo = 1'b0; break; end
            @(negedge clk);
            n++;
        end
        chk("ign_timeout", {31'd0, r_tmo}, 32'd0);
        chk("ign_result",  result, 32'd445);
        chk("ign_latency", n, 200);
        done_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("ign_no_second_done", done_seen, 0);
        chk("ign_result_held", result, 32'd445);

        // Reset mid-operation aborts
        @(negedge clk);
        base = 32'd1; exp = 32'hFFFF_FFFF; modulus = 32'hFFFF_FFFB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_result", result,        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        done_seen = 0;
        repeat (2200) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        // Random regression against the reference model
        for (int t = 0; t < 150; t++) begin
            logic [31:0] rb, re, rm;
            int          w;
            rb = $urandom;
            w  = $urandom_range(1, 6);
            re = $urandom & ((32'd1 << w) - 32'd1);
            rm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(2, 50)) : $urandom;
            if (rm < 2) rm = 32'd2;
            run_op(rb, re, rm, r_res, r_er, r_lat, r_tmo);
            chk($sformatf("rnd%0d_timeout", t), {31'd0, r_tmo}, 32'd0);
            chk($sformatf("rnd%0d_result",  t), r_res, ref_pow(rb, re, rm));
            chk($sformatf("rnd%0d_err",     t), {31'd0, r_er}, 32'd0);
            chk($sformatf("rnd%0d_latency", t), r_lat, ref_lat(re, rm));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            chk($sformatf("rnd%0d_hold", t), result, ref_pow(rb, re, rm));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
